// File: rtl/adder_result_checker.sv
// adder_result_checker
//   Downstream self-check stage for the adder. Accepts {a, b, sum, cout}
//   vectors during a run, recomputes the reference sum one cycle later and
//   keeps saturating pass/fail tallies. The operands of the first failing
//   vector of a run are retained.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start             : pulse; begins a run from IDLE or DONE, clears results
//   in_valid/in_ready : vector handshake, ready only while running
//   a, b, sum, cout   : operands and adder result under test
//   in_last           : marks the final vector of the run
//   busy, done        : run in progress / run finished, results stable
//   pass_count,
//   fail_count        : saturating tallies
//   err               : sticky mismatch flag for the current run
//   fail_a, fail_b    : operands of the first mismatch in the current run
module adder_result_checker #(
  parameter int CNT_W = 16,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic [DW-1:0]    sum,
  input  logic             cout,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err,
  output logic [DW-1:0]    fail_a,
  output logic [DW-1:0]    fail_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic          stg_valid;
  logic [DW-1:0] stg_a;
  logic [DW-1:0] stg_b;
  logic [DW-1:0] stg_sum;
  logic          stg_cout;
  logic          stg_last;

  logic          xfer;
  logic          launch;
  logic [DW:0]   ref_sum;
  logic          match;

  always_comb begin
    xfer     = in_valid && (state == RUN);
    launch   = start && ((state == IDLE) || (state == DONE));
    ref_sum  = {1'b0, stg_a} + {1'b0, stg_b};
    match    = ({stg_cout, stg_sum} == ref_sum);
    in_ready = (state == RUN);
    busy     = (state == RUN) || (state == DRAIN);
    done     = (state == DONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (xfer && in_last) state_nxt = DRAIN;
      // DRAIN is only entered with the last vector staged, so this is the
      // edge that tallies it.
      DRAIN:   if (stg_valid && stg_last) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid  <= 1'b0;
      stg_a      <= '0;
      stg_b      <= '0;
      stg_sum    <= '0;
      stg_cout   <= 1'b0;
      stg_last   <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
      err        <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      stg_valid <= xfer;
      if (xfer) begin
        stg_a    <= a;
        stg_b    <= b;
        stg_sum  <= sum;
        stg_cout <= cout;
        stg_last <= in_last;
      end
      // The stage is always empty in IDLE/DONE, so a launch never collides
      // with a pending tally.
      if (launch) begin
        pass_count <= '0;
        fail_count <= '0;
        err        <= 1'b0;
        fail_a     <= '0;
        fail_b     <= '0;
      end else if (stg_valid) begin
        if (match) begin
          if (pass_count != '1) pass_count <= pass_count + 1'b1;
        end else begin
          if (fail_count != '1) fail_count <= fail_count + 1'b1;
          err <= 1'b1;
          if (!err) begin
            fail_a <= stg_a;
            fail_b <= stg_b;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
module tb_adder_result_checker;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, cout;
  logic [15:0] a, b, sum;
  logic        in_ready, busy, done, err;
  logic [15:0] pass_count, fail_count, fail_a, fail_b;

  logic        start4, in_valid4;
  logic        in_ready4, busy4, done4, err4;
  logic [3:0]  pass_count4, fail_count4;
  logic [15:0] fail_a4, fail_b4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_result_checker #(.CNT_W(16), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .sum(sum), .cout(cout),
    .in_last(in_last), .busy(busy), .done(done),
    .pass_count(pass_count), .fail_count(fail_count), .err(err),
    .fail_a(fail_a), .fail_b(fail_b)
  );

  adder_result_checker #(.CNT_W(4), .DW(16)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid4),
    .in_ready(in_ready4), .a(a), .b(b), .sum(sum), .cout(cout),
    .in_last(in_last), .busy(busy4), .done(done4),
    .pass_count(pass_count4), .fail_count(fail_count4), .err(err4),
    .fail_a(fail_a4), .fail_b(fail_b4)
  );

  // Reference model for the 16-bit instance
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} m_state_t;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ok;
    logic        last;
  } sb_t;

  sb_t         sb_q[$];
  m_state_t    m_state = M_IDLE;
  logic [15:0] m_pass = '0, m_fail = '0, m_fa = '0, m_fb = '0;
  logic        m_err = 1'b0;

  // Advance one clock: model is updated from the driven inputs at the edge,
  // and the task returns at the following falling edge for sampling.
  task automatic tick();
    m_state_t prev;
    sb_t      e;
    logic [16:0] exp_sum;
    @(posedge clk);
    prev = m_state;
    if (rst) begin
      sb_q.delete();
      m_state = M_IDLE;
      m_pass = '0; m_fail = '0; m_fa = '0; m_fb = '0; m_err = 1'b0;
    end else begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.ok) begin
          if (m_pass != 16'hFFFF) m_pass = m_pass + 16'd1;
        end else begin
          if (m_fail != 16'hFFFF) m_fail = m_fail + 16'd1;
          if (!m_err) begin m_fa = e.a; m_fb = e.b; end
          m_err = 1'b1;
        end
        if (prev == M_DRAIN && e.last) m_state = M_DONE;
      end
      if (start && (prev == M_IDLE || prev == M_DONE)) begin
        m_pass = '0; m_fail = '0; m_fa = '0; m_fb = '0; m_err = 1'b0;
        m_state = M_RUN;
      end else if (prev == M_RUN && in_valid) begin
        exp_sum = {1'b0, a} + {1'b0, b};
        e.a = a; e.b = b; e.last = in_last;
        e.ok = ({cout, sum} == exp_sum);
        sb_q.push_back(e);
        if (in_last) m_state = M_DRAIN;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [3:0] exp_status();
    return {m_state == M_RUN, (m_state == M_RUN) || (m_state == M_DRAIN),
            m_state == M_DONE, m_err};
  endfunction

  task automatic drive(input logic [15:0] va, input logic [15:0] vb,
                       input logic [16:0] res, input logic last);
    a = va; b = vb; {cout, sum} = res; in_last = last; in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in_valid = 1'b1;
    tick();
    checks++;
    if ({in_ready, busy, done, err} !== 4'b0000) begin
      errors++; $display("FAIL reset_status got %b exp 0000", {in_ready, busy, done, err});
    end
    checks++;
    if ({pass_count, fail_count, fail_a, fail_b} !== 64'd0) begin
      errors++; $display("FAIL reset_regs got %h exp 0", {pass_count, fail_count, fail_a, fail_b});
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if ({in_ready, busy, done, err} !== exp_status()) begin
      errors++; $display("FAIL reset_idle got %b exp %b", {in_ready, busy, done, err}, exp_status());
    end
  endtask

  task automatic test_single();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({in_ready, busy, done} !== 3'b110) begin
      errors++; $display("FAIL single_run got %b exp 110", {in_ready, busy, done});
    end
    drive(16'h0001, 16'h0001, 17'h00002, 1'b1);
    tick(); in_valid = 1'b0;
    checks++;
    if ({in_ready, busy, done, pass_count} !== {3'b010, 16'd0}) begin
      errors++; $display("FAIL single_drain got %b/%0d exp 010/0", {in_ready, busy, done}, pass_count);
    end
    tick();
    checks++;
    if ({done, busy, err, pass_count, fail_count} !== {3'b100, 16'd1, 16'd0}) begin
      errors++; $display("FAIL single_done got d%b b%b e%b p%0d f%0d exp d1 b0 e0 p1 f0",
                         done, busy, err, pass_count, fail_count);
    end
    // in_valid while DONE must not change anything
    drive(16'h0005, 16'h0005, 17'h00000, 1'b1);
    tick(); tick(); in_valid = 1'b0;
    checks++;
    if ({done, pass_count, fail_count} !== {1'b1, m_pass, m_fail}) begin
      errors++; $display("FAIL single_hold got d%b p%0d f%0d exp d1 p%0d f%0d",
                         done, pass_count, fail_count, m_pass, m_fail);
    end
  endtask

  task automatic test_carry();
    start = 1'b1; tick(); start = 1'b0;
    drive(16'hFFFF, 16'hFFFF, 17'h1FFFE, 1'b0);
    tick();
    drive(16'hFFFF, 16'hFFFF, 17'h0FFFE, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if ({pass_count, fail_count, err} !== {16'd1, 16'd0, 1'b0}) begin
      errors++; $display("FAIL carry_pass got p%0d f%0d e%b exp p1 f0 e0", pass_count, fail_count, err);
    end
    tick();
    checks++;
    if ({pass_count, fail_count, err, done} !== {m_pass, m_fail, m_err, 1'b1}) begin
      errors++; $display("FAIL carry_counts got p%0d f%0d e%b d%b exp p%0d f%0d e%b d1",
                         pass_count, fail_count, err, done, m_pass, m_fail, m_err);
    end
    checks++;
    if ({fail_a, fail_b} !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL carry_ops got %h/%h exp ffff/ffff", fail_a, fail_b);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va, vb;
    logic [16:0] res;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 49; i++) begin
      if (i < 30) begin
        va = 16'(i + 1); vb = va;
      end else if (i < 35) begin
        case (i)
          30: va = 16'hFFFF;
          31: va = 16'hFFEE;
          32: va = 16'hFEEF;
          33: va = 16'hF1EF;
          default: va = 16'h0110;
        endcase
        vb = va;
      end else begin
        va = 16'(i * 16'h0101); vb = 16'hF00F ^ 16'(i);
      end
      res = {1'b0, va} + {1'b0, vb};
      if (i == 2) res = 17'h00007;
      drive(va, vb, res, i == 48);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_bubble vec %0d in_ready got %b exp 1", i, in_ready);
      end
      tick();
      checks++;
      if ({pass_count, fail_count, err} !== {m_pass, m_fail, m_err}) begin
        errors++; $display("FAIL b2b_tally vec %0d got p%0d f%0d e%b exp p%0d f%0d e%b",
                           i, pass_count, fail_count, err, m_pass, m_fail, m_err);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({pass_count, fail_count, fail_a, fail_b, done} !==
        {16'd48, 16'd1, 16'h0003, 16'h0003, 1'b1}) begin
      errors++; $display("FAIL b2b_final got p%0d f%0d fa%h fb%h d%b exp p48 f1 fa0003 fb0003 d1",
                         pass_count, fail_count, fail_a, fail_b, done);
    end
  endtask

  task automatic test_two_fail();
    start = 1'b1; tick(); start = 1'b0;
    drive(16'h0005, 16'h0001, 17'h00000, 1'b0);
    tick();
    drive(16'h000A, 16'h0002, 17'h00000, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({fail_count, pass_count, err, done} !== {16'd2, 16'd0, 2'b11}) begin
      errors++; $display("FAIL two_fail_counts got f%0d p%0d e%b d%b exp f2 p0 e1 d1",
                         fail_count, pass_count, err, done);
    end
    checks++;
    if ({fail_a, fail_b} !== {m_fa, m_fb} || fail_a !== 16'h0005) begin
      errors++; $display("FAIL two_fail_ops got %h/%h exp %h/%h", fail_a, fail_b, m_fa, m_fb);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; tick(); start = 1'b0;
    drive(16'h0003, 16'h0004, 17'h00009, 1'b0);
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, busy, done, err, pass_count, fail_count, fail_a, fail_b} !== 68'd0) begin
      errors++; $display("FAIL rst_mid got st%b p%0d f%0d fa%h fb%h exp all 0",
                         {in_ready, busy, done, err}, pass_count, fail_count, fail_a, fail_b);
    end
    tick();
    checks++;
    if ({fail_count, err} !== {m_fail, m_err}) begin
      errors++; $display("FAIL rst_discard got f%0d e%b exp f%0d e%b", fail_count, err, m_fail, m_err);
    end
    start = 1'b1; tick(); start = 1'b0;
    drive(16'h0010, 16'h0020, 17'h00030, 1'b1);
    tick();
    // start and a bad vector presented while draining are ignored
    start = 1'b1;
    drive(16'h0001, 16'h0001, 17'h00000, 1'b1);
    tick();
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if ({done, busy, pass_count, fail_count} !== {2'b10, 16'd1, 16'd0}) begin
      errors++; $display("FAIL drain_ignore got d%b b%b p%0d f%0d exp d1 b0 p1 f0",
                         done, busy, pass_count, fail_count);
    end
    tick();
    checks++;
    if ({in_ready, busy, done, err} !== exp_status() || pass_count !== m_pass || fail_count !== 16'd0) begin
      errors++; $display("FAIL drain_hold got st%b p%0d f%0d exp st%b p%0d f0",
                         {in_ready, busy, done, err}, pass_count, fail_count, exp_status(), m_pass);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_p;
    start4 = 1'b1; tick(); start4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a = 16'(i * 7); b = 16'(i + 100);
      {cout, sum} = {1'b0, a} + {1'b0, b};
      in_last = (i == 19);
      in_valid4 = 1'b1;
      tick();
      exp_p = (i > 15) ? 4'd15 : 4'(i);
      checks++;
      if (pass_count4 !== exp_p) begin
        errors++; $display("FAIL sat_count vec %0d got %0d exp %0d", i, pass_count4, exp_p);
      end
    end
    in_valid4 = 1'b0;
    tick();
    checks++;
    if ({pass_count4, fail_count4, done4, err4} !== {4'd15, 4'd0, 2'b10}) begin
      errors++; $display("FAIL sat_final got p%0d f%0d d%b e%b exp p15 f0 d1 e0",
                         pass_count4, fail_count4, done4, err4);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    a = '0; b = '0; sum = '0; cout = 1'b0;
    start4 = 1'b0; in_valid4 = 1'b0;
    @(negedge clk);
    tick();
    test_reset();
    test_single();
    test_carry();
    test_back_to_back();
    test_two_fail();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
